cic_chan_sched: RTL
===================

CIC_CHAN_SCHED -- requirements
Module: cic_chan_sched

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning the number of input channels (power of two, 2..8).
REQ-002 The block SHALL have parameter DW, default 8, meaning the sample width, matching the integrator data_in width.
REQ-003 The block SHALL have parameter RW, default 8, meaning the width of the decimation-ratio field.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port enable, input, 1 bit: run request.
REQ-007 The block SHALL have port dec_ratio, input, RW bits: decimation ratio R.
REQ-008 The block SHALL have port ch_data, input, NCH*DW bits: channel samples, with channel i at bits [i*DW +: DW].
REQ-009 The block SHALL have port ch_valid, input, NCH bits: per-channel sample valid.
REQ-010 The block SHALL have port ch_ready, output, NCH bits: per-channel accept, one-hot or zero.
REQ-011 The block SHALL have port data_in, output, DW bits: sample to the shared integrator.
REQ-012 The block SHALL have port in_dv, output, 1 bit: integrator data valid.
REQ-013 The block SHALL have port in_ch, output, log2(NCH) bits: channel tag for data_in.
REQ-014 The block SHALL have port comb_strobe, output, 1 bit: decimation point reached for in_ch.
REQ-015 The block SHALL have port busy, output, 1 bit: high when the state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-017 In IDLE, enable=1 SHALL cause a transition to RUN and latch dec_ratio into R_q.
REQ-018 In RUN, enable=0 SHALL cause a transition to DRAIN.
REQ-019 DRAIN SHALL last exactly 1 cycle and then go to IDLE.
REQ-020 Changes to dec_ratio outside the IDLE->RUN transition SHALL be ignored.
REQ-021 ch_ready SHALL be 0 in IDLE and DRAIN.
REQ-022 In RUN, ch_ready SHALL be combinational from ch_valid and the registered pointer: one-hot on the first valid channel searching ptr+1, ptr+2, ... with wrap-around, and zero when no channel is valid.
REQ-023 A transfer SHALL occur when ch_valid[i] and ch_ready[i] are both high.
REQ-024 On a transfer, ptr SHALL be set to i; otherwise ptr SHALL hold.
REQ-025 Latency SHALL be 1: the cycle after a transfer on channel i, in_dv=1, data_in=the channel's sample, and in_ch=i.
REQ-026 in_dv SHALL be 0 in any cycle that does not follow a transfer.
REQ-027 Each channel SHALL have a counter cnt[i] of width RW.
REQ-028 On a transfer for channel i, when cnt[i]==R_q-1, cnt[i] SHALL return to 0 and comb_strobe SHALL be 1, aligned with that sample's in_dv; otherwise cnt[i] SHALL increment.
REQ-029 R_q of 0 or 1 SHALL assert comb_strobe on every sample.
REQ-030 comb_strobe SHALL never be high while in_dv=0.
REQ-031 Entry to DRAIN SHALL clear all cnt[i] and reset ptr to NCH-1.
REQ-032 A transfer accepted in the last RUN cycle SHALL still be output in the DRAIN cycle.
REQ-033 A valid channel SHALL be granted within NCH cycles, with no starvation.

Reset
REQ-034 reset_n=0 SHALL immediately force state=IDLE, ptr=NCH-1, all cnt=0, R_q=0, and data_in, in_dv, in_ch, comb_strobe and busy to 0, with ch_ready=0.
REQ-035 A reset asserted mid-RUN SHALL drop any pending output sample.
REQ-036 The first grant after reset SHALL go to channel 0.

Configuration
REQ-037 When CIC_SCHED_PRIO_EN is defined, channel 0 SHALL have strict priority: it is granted whenever it is valid, and the round-robin pointer covers channels 1..NCH-1 only.
REQ-038 When CIC_SCHED_PRIO_EN is undefined, all NCH channels SHALL be in pure round-robin.

Structure
REQ-039 Package cic_pkg SHALL hold the FSM state enum (IDLE, RUN, DRAIN) and the default constants CIC_NCH=4 and CIC_DW=8.
REQ-040 The round-robin search SHALL be a separate sub-module, cic_rr_pick, with inputs req[NCH] and ptr, and output gnt one-hot.

Verification
REQ-041 Scenario: reset, then enable=1 with dec_ratio=4 and only ch0 valid, ch0 data 0x01..0x08 -> in_dv on 8 consecutive cycles, comb_strobe on the 4th and 8th samples, busy=1.
REQ-042 Scenario: all 4 channels continuously valid -> in_ch sequence 0,1,2,3,0,... and each ch_ready high 1 cycle in 4.
REQ-043 Scenario: dec_ratio=1 -> comb_strobe equals in_dv on every cycle; dec_ratio=0 -> same.
REQ-044 Scenario: enable dropped on the same cycle as a ch2 transfer of 0xFF -> in_dv=1 with data_in=255 and in_ch=2 during DRAIN, then IDLE and busy=0; after re-enable, the first grant goes to ch0 and the counters restart.
REQ-045 Scenario: reset_n pulsed low mid-RUN with dec_ratio=3 after 2 ch1 samples -> outputs 0 immediately; after re-enable, the ch1 strobe falls on the 3rd new sample.
REQ-046 Scenario: with CIC_SCHED_PRIO_EN defined and ch0 and ch1 always valid -> in_ch stays at 0 for every sample; when ch0 deasserts, ch1 is granted the next cycle.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared constants and FSM state type for the CIC channel scheduler.
package cic_pkg;

  localparam int unsigned CIC_NCH = 4;
  localparam int unsigned CIC_DW  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } cic_state_e;

endpackage : cic_pkg

// File: rtl/cic_rr_pick.sv
// Round-robin picker: grants the first requester after ptr, wrapping around.
// NCH must be a power of two so the index arithmetic wraps naturally.
module cic_rr_pick #(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] ptr,
  output logic [NCH-1:0]         gnt
);

  localparam int unsigned PW = $clog2(NCH);

  logic [PW-1:0] idx;
  logic          found;

  // Search ptr+1, ptr+2, ... ptr+NCH and grant the first active request.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = ptr;
    for (int unsigned k = 1; k <= NCH; k++) begin
      idx = ptr + PW'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule : cic_rr_pick

// File: rtl/cic_chan_sched.sv
// CIC channel scheduler: multiplexes NCH sample streams into one shared
// integrator, tagging each sample with its channel and flagging the
// per-channel decimation point on comb_strobe.
// Optional feature: define CIC_SCHED_PRIO_EN to give channel 0 strict
// priority over a round-robin among channels 1..NCH-1.
module cic_chan_sched
  import cic_pkg::*;
#(
  parameter int unsigned NCH = CIC_NCH,
  parameter int unsigned DW  = CIC_DW,
  parameter int unsigned RW  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [RW-1:0]          dec_ratio,
  input  logic [NCH*DW-1:0]      ch_data,
  input  logic [NCH-1:0]         ch_valid,
  output logic [NCH-1:0]         ch_ready,
  output logic [DW-1:0]          data_in,
  output logic                   in_dv,
  output logic [$clog2(NCH)-1:0] in_ch,
  output logic                   comb_strobe,
  output logic                   busy
);

  localparam int unsigned PW = $clog2(NCH);

  cic_state_e    state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [RW-1:0] cnt_q [NCH];
  logic [RW-1:0] cnt_d [NCH];
  logic [DW-1:0] data_q, data_d;
  logic          dv_q, dv_d;
  logic [PW-1:0] ch_q, ch_d;
  logic          strobe_q, strobe_d;
  logic          busy_q, busy_d;

  logic [NCH-1:0] rr_req;
  logic [NCH-1:0] rr_gnt;
  logic [NCH-1:0] gnt;

`ifdef CIC_SCHED_PRIO_EN
  // Channel 0 bypasses the rotation; the picker only sees channels 1..NCH-1.
  assign rr_req = ch_valid & ~NCH'(1);
  assign gnt    = ch_valid[0] ? NCH'(1) : rr_gnt;
`else
  // All channels share the rotation equally.
  assign rr_req = ch_valid;
  assign gnt    = rr_gnt;
`endif

  cic_rr_pick #(
    .NCH (NCH)
  ) u_pick (
    .req (rr_req),
    .ptr (ptr_q),
    .gnt (rr_gnt)
  );

  // Accept only while running; the grant is already qualified by ch_valid.
  assign ch_ready = (state_q == RUN) ? gnt : '0;

  // Next-state: FSM, ratio latch, transfer capture and decimation counters.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    dv_d     = 1'b0;
    ch_d     = ch_q;
    strobe_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          r_d     = dec_ratio;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch_ready[i]) begin
        dv_d   = 1'b1;
        data_d = ch_data[i*DW +: DW];
        ch_d   = PW'(i);
        if ((r_q <= RW'(1)) || (cnt_q[i] == r_q - RW'(1))) begin
          strobe_d = 1'b1;
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + RW'(1);
        end
`ifdef CIC_SCHED_PRIO_EN
        if (i != 0) begin
          ptr_d = PW'(i);
        end
`else
        ptr_d = PW'(i);
`endif
      end
    end

    // Leaving RUN restarts every channel's decimation phase and the rotation;
    // the sample accepted in this last cycle is still emitted during DRAIN.
    if ((state_q == RUN) && !enable) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_d[i] = '0;
      end
      ptr_d = PW'(NCH - 1);
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      r_q      <= '0;
      ptr_q    <= PW'(NCH - 1);
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
      data_q   <= '0;
      dv_q     <= 1'b0;
      ch_q     <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      dv_q     <= dv_d;
      ch_q     <= ch_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
    end
  end

  assign data_in     = data_q;
  assign in_dv       = dv_q;
  assign in_ch       = ch_q;
  assign comb_strobe = strobe_q;
  assign busy        = busy_q;

endmodule : cic_chan_sched
